// File: rtl/vga_rect_writer_if.sv
// vga_rect_writer_if: draw command inputs and pixel write port of the rectangle writer
interface vga_rect_writer_if #(
  parameter int COLOR_DEPTH = 3,
  parameter int nX = 8,
  parameter int nY = 7
);
  logic                   start;
  logic                   clear;
  logic [nX-1:0]          x0;
  logic [nY-1:0]          y0;
  logic [nX-1:0]          width;
  logic [nY-1:0]          height;
  logic [COLOR_DEPTH-1:0] color;
  logic [nX-1:0]          x;
  logic [nY-1:0]          y;
  logic [COLOR_DEPTH-1:0] colour;
  logic                   plot;
  logic                   busy;
  logic                   done;
  modport master (output start, clear, x0, y0, width, height, color,
                  input x, y, colour, plot, busy, done);
  modport slave (input start, clear, x0, y0, width, height, color,
                 output x, y, colour, plot, busy, done);
endinterface

// File: rtl/vga_rect_writer.sv
// vga_rect_writer: fills a clipped rectangle or the whole screen, one pixel write per clock
module vga_rect_writer #(
  parameter int COLOR_DEPTH = 3,
  parameter int nX = 8,
  parameter int nY = 7,
  parameter int COLS = 160,
  parameter int ROWS = 120
) (
  input logic clock,
  input logic reset,
  vga_rect_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
  localparam logic [nX:0] COLS_W = (nX+1)'(COLS);
  localparam logic [nY:0] ROWS_W = (nY+1)'(ROWS);
  state_t state_q, state_d;
  logic [nX-1:0] x0_q, x0_d, w_q, w_d, xe_q, xe_d, x_q, x_d;
  logic [nY-1:0] y0_q, y0_d, h_q, h_d, ye_q, ye_d, y_q, y_d;
  logic [COLOR_DEPTH-1:0] col_q, col_d, colour_q, colour_d;
  logic [nX:0] xs, xm;
  logic [nY:0] ys, ym;
  logic empty, row_end, last;
  always_comb begin
    state_d = state_q;
    x0_d = x0_q;
    y0_d = y0_q;
    w_d = w_q;
    h_d = h_q;
    col_d = col_q;
    xe_d = xe_q;
    ye_d = ye_q;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    xs = {1'b0, x0_q} + {1'b0, w_q};
    ys = {1'b0, y0_q} + {1'b0, h_q};
    xm = (xs > COLS_W ? COLS_W : xs) - 1'b1;
    ym = (ys > ROWS_W ? ROWS_W : ys) - 1'b1;
    empty = w_q == '0 || h_q == '0 || {1'b0, x0_q} >= COLS_W || {1'b0, y0_q} >= ROWS_W;
    row_end = x_q == xe_q;
    last = row_end && y_q == ye_q;
    case (state_q)
      IDLE: if (bus.clear || bus.start) begin
        state_d = LOAD;
        x0_d = bus.clear ? '0 : bus.x0;
        y0_d = bus.clear ? '0 : bus.y0;
        w_d = bus.clear ? nX'(COLS) : bus.width;
        h_d = bus.clear ? nY'(ROWS) : bus.height;
        col_d = bus.color;
      end
      LOAD: begin
        state_d = empty ? DONE : DRAW;
        xe_d = xm[nX-1:0];
        ye_d = ym[nY-1:0];
        colour_d = col_q;
        x_d = empty ? x_q : x0_q;
        y_d = empty ? y_q : y0_q;
      end
      DRAW: begin
        state_d = last ? DONE : DRAW;
        x_d = last ? x_q : (row_end ? x0_q : x_q + 1'b1);
        y_d = (row_end && !last) ? y_q + 1'b1 : y_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      w_q <= w_d;
      h_q <= h_d;
      col_q <= col_d;
      xe_q <= xe_d;
      ye_q <= ye_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
    end
  end
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.colour = colour_q;
  assign bus.plot = state_q == DRAW;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_vga_rect_writer.sv
// tb_vga_rect_writer: random and directed draw commands checked by a pixel scoreboard
module tb_vga_rect_writer;
  localparam int COLS = 160, ROWS = 120;
  logic clock = 0, reset = 1;
  int total = 0, bad = 0, seen = 0;
  logic [17:0] exp_q[$];
  int cnt_q[$];
  vga_rect_writer_if #(.COLOR_DEPTH(3), .nX(8), .nY(7)) bus ();
  vga_rect_writer #(.COLOR_DEPTH(3), .nX(8), .nY(7), .COLS(COLS), .ROWS(ROWS)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic model(input int ax, input int ay, input int aw, input int ah, input int ac, output int n);
    n = 0;
    for (int yy = ay; yy < ay + ah && yy < ROWS; yy++)
      for (int xx = ax; xx < ax + aw && xx < COLS; xx++) begin
        exp_q.push_back({8'(xx), 7'(yy), 3'(ac)});
        n++;
      end
    cnt_q.push_back(n);
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.plot) begin
        if (exp_q.size() == 0) check("unexpected_plot", 1, 0);
        else check("pixel", int'({bus.x, bus.y, bus.colour}), int'(exp_q.pop_front()));
        seen++;
      end
      if (bus.done) begin
        check("done_pixel_count", seen, cnt_q.size() != 0 ? cnt_q.pop_front() : -1);
        seen = 0;
      end
    end
  end
  task automatic issue(input bit s, input bit c, input int ax, input int ay, input int aw, input int ah,
                       input int ac, input int poke);
    int n, waited;
    if (c) model(0, 0, COLS, ROWS, ac, n);
    else model(ax, ay, aw, ah, ac, n);
    bus.start = s; bus.clear = c;
    bus.x0 = 8'(ax); bus.y0 = 7'(ay); bus.width = 8'(aw); bus.height = 7'(ah); bus.color = 3'(ac);
    @(negedge clock);
    bus.start = 0; bus.clear = 0;
    bus.x0 = 8'($urandom); bus.y0 = 7'($urandom); bus.width = 8'($urandom);
    bus.height = 7'($urandom); bus.color = 3'($urandom);
    check("load_busy", int'(bus.busy), 1);
    check("load_plot", int'(bus.plot), 0);
    @(negedge clock);
    if (n == 0) check("empty_done", int'(bus.done), 1);
    else begin
      check("first_plot", int'(bus.plot), 1);
      waited = 0;
      while (!bus.done && waited < n + 5) begin
        bus.start = (waited == poke);
        @(negedge clock);
        waited++;
      end
      bus.start = 0;
      check("done_latency", waited, n);
      check("done_seen", int'(bus.done), 1);
    end
    @(negedge clock);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
  endtask
  initial begin
    bus.start = 0; bus.clear = 0; bus.x0 = 0; bus.y0 = 0; bus.width = 0; bus.height = 0; bus.color = 0;
    repeat (3) @(negedge clock);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_xyc", int'({bus.x, bus.y, bus.colour}), 0);
    reset = 0;
    @(negedge clock);
    issue(1, 0, 10, 5, 2, 2, 4, -1);
    issue(1, 0, 10, 5, 0, 7, 2, -1);
    issue(1, 0, 160, 5, 3, 3, 2, -1);
    issue(1, 0, 3, 120, 3, 3, 6, -1);
    issue(1, 0, 158, 118, 4, 4, 7, -1);
    issue(1, 0, 20, 20, 4, 4, 5, 2);
    for (int i = 0; i < 20; i++)
      issue(1, 0, $urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 20),
            $urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 1) ? int'($urandom_range(0, 6)) : -1);
    issue(0, 1, 5, 5, 1, 1, 1, -1);
    issue(1, 1, 30, 40, 2, 2, 6, 100);
    bus.start = 1; bus.x0 = 20; bus.y0 = 30; bus.width = 10; bus.height = 10; bus.color = 5;
    begin
      int n;
      model(20, 30, 10, 10, 5, n);
    end
    @(negedge clock);
    bus.start = 0;
    repeat (5) @(negedge clock);
    check("pre_reset_plot", int'(bus.plot), 1);
    reset = 1;
    @(negedge clock);
    check("abort_plot", int'(bus.plot), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_xyc", int'({bus.x, bus.y, bus.colour}), 0);
    reset = 0;
    exp_q.delete();
    cnt_q.delete();
    seen = 0;
    @(negedge clock);
    check("abort_stays_idle", int'(bus.plot | bus.busy), 0);
    issue(1, 0, 50, 60, 3, 2, 3, -1);
    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size() + cnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_rect_writer.md
Name: vga_rect_writer

Overview:
- Drawing engine on the write side of the video memory. It fills an axis-aligned rectangle, or the whole screen, with one colour.
- It emits one pixel write per clock on x/y/colour/plot, which feed the adapter's write port.
- Sits between the step-sequencer UI logic, which issues draw commands, and the VGA adapter. The VGA controller independently scans the same memory for display.

Parameters:
COLOR_DEPTH, 3, bits per pixel colour
nX, 8, x coordinate width
nY, 7, y coordinate width
COLS, 160, screen width in pixels
ROWS, 120, screen height in pixels

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin rectangle draw with x0/y0/width/height/color
clear  input  1  one-cycle pulse: fill full screen (0,0)-(COLS-1,ROWS-1) with color
x0  input  nX  rectangle left column
y0  input  nY  rectangle top row
width  input  nX  rectangle width in pixels (0 = empty)
height  input  nY  rectangle height in pixels (0 = empty)
color  input  COLOR_DEPTH  fill colour
x  output  nX  write column (registered)
y  output  nY  write row (registered)
colour  output  COLOR_DEPTH  write colour (registered)
plot  output  1  write strobe; memory written at (x,y) when 1
busy  output  1  1 from cycle after accepted command through DONE cycle
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset: synchronous, active-high; wins over all other inputs. Next edge: state IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0. Reset mid-draw aborts; no further plot.
- FSM states:
  - IDLE: busy=0, plot=0. start or clear at an edge accepts the command. clear has priority over start when both are asserted.
  - LOAD: one cycle, busy=1, plot=0. Computes clipped extents.
  - DRAW: plot=1 every cycle, one pixel per cycle.
  - DONE: one cycle, done=1, busy=1, plot=0, then return to IDLE.
- Command latch (in IDLE on accept): register x0, y0, width, height, color. clear substitutes 0, 0, COLS, ROWS.
- Extent arithmetic (LOAD), in nX+1 / nY+1 bits, no wrap:
  - xe = min(x0+width, COLS) - 1; ye = min(y0+height, ROWS) - 1.
  - Empty if width==0, height==0, x0>=COLS or y0>=ROWS.
  - Empty → LOAD goes straight to DONE with zero plot cycles.
- Scan: first DRAW cycle outputs (x0,y0). Each subsequent cycle:
  - if x==xe: x←x0, y←y+1
  - else: x←x+1
  - After the cycle presenting (xe,ye), next state is DONE.
- Pixel writes per command = (xe-x0+1)*(ye-y0+1), in row-major order. Each (x,y) is written exactly once.
- Latency: accept edge → LOAD → first plot on the 2nd cycle after the accepting edge. The DONE pulse comes the cycle after the last plot.
- colour holds the latched colour throughout DRAW; it is held (not zeroed) after completion.
- Commands while busy=1 (LOAD/DRAW/DONE) are ignored, not queued.
- Inputs other than start/clear may change freely after acceptance without affecting the draw in progress.
- x/y hold their last values in IDLE/DONE; consumers qualify them only by plot.

Test Plan:
- Reset, then start with x0=10,y0=5,width=2,height=2,color=3'b100 → plot=1 for exactly 4 cycles at (10,5),(11,5),(10,6),(11,6), colour=3'b100; first plot 2 cycles after start; done=1 for one cycle right after; busy=0 next cycle.
- start with width=0,height=7 (and separately x0=160) → zero plot cycles; done pulses 2 cycles after start.
- Clipping: x0=158,y0=118,width=4,height=4 → exactly 4 plots at (158,118),(159,118),(158,119),(159,119); no coordinate ≥160 or ≥120.
- clear with color=3'b001 → 19200 consecutive plot cycles covering (0,0)…(159,119) in row-major order, each once, colour=3'b001; then one done pulse.
- start pulsed again at cycle 3 of a 4x4 draw, and start+clear asserted together from IDLE → the second start is ignored (16 plots total); simultaneous start+clear executes the clear.
- reset asserted on the 5th plot cycle of a 10x10 draw → next edge plot=0, busy=0, done=0, x=y=colour=0; a new start then draws normally.
